// File: rtl/branch_update_queue.sv
// In-order branch tracker between dispatch and the global-history predictor.
// Entries are allocated in program order, resolved out of order, and retired from the head.
module branch_update_queue #(
  parameter int DEPTH = 8,
  parameter int TAG_W = 3,
  parameter int IDX_W = 5
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             alloc_valid,
  input  logic [IDX_W-1:0] alloc_pht_index,
  input  logic             alloc_prediction,
  output logic             alloc_ready,
  output logic [TAG_W-1:0] alloc_tag,
  input  logic             resolve_valid,
  input  logic [TAG_W-1:0] resolve_tag,
  input  logic             resolve_taken,
  output logic             update_valid,
  output logic [IDX_W-1:0] update_pht_index,
  output logic             update_result,
  output logic             mispredict,
  output logic [TAG_W:0]   count
);

  logic [DEPTH-1:0] valid_q;
  logic [DEPTH-1:0] resolved_q;
  logic [DEPTH-1:0] taken_q;
  logic [DEPTH-1:0] pred_q;
  logic [IDX_W-1:0] pht_q [DEPTH];
  logic [TAG_W-1:0] head;
  logic [TAG_W-1:0] tail;
  logic [TAG_W:0]   count_q;
  logic             alloc_fire;
  logic             resolve_ok;

  // Retirement view is purely registered state, so a resolve is seen one cycle later.
  always_comb begin
    update_valid     = valid_q[head] && resolved_q[head];
    update_pht_index = update_valid ? pht_q[head] : '0;
    update_result    = update_valid ? taken_q[head] : 1'b0;
    mispredict       = update_valid && (taken_q[head] != pred_q[head]);
    alloc_ready      = (count_q != (TAG_W+1)'(DEPTH)) && !mispredict;
    alloc_tag        = tail;
    count            = count_q;
    alloc_fire       = alloc_valid && alloc_ready;
    resolve_ok       = resolve_valid && valid_q[resolve_tag] && !resolved_q[resolve_tag];
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      valid_q    <= '0;
      resolved_q <= '0;
      head       <= '0;
      tail       <= '0;
      count_q    <= '0;
    end else if (mispredict) begin
      // Everything younger than the mispredicted head is on the wrong path.
      valid_q    <= '0;
      resolved_q <= '0;
      head       <= '0;
      tail       <= '0;
      count_q    <= '0;
    end else begin
      if (resolve_ok) begin
        resolved_q[resolve_tag] <= 1'b1;
        taken_q[resolve_tag]    <= resolve_taken;
      end
      if (update_valid) begin
        valid_q[head]    <= 1'b0;
        resolved_q[head] <= 1'b0;
        head             <= head + TAG_W'(1);
      end
      if (alloc_fire) begin
        valid_q[tail]    <= 1'b1;
        resolved_q[tail] <= 1'b0;
        pred_q[tail]     <= alloc_prediction;
        pht_q[tail]      <= alloc_pht_index;
        tail             <= tail + TAG_W'(1);
      end
      if (alloc_fire && !update_valid)
        count_q <= count_q + (TAG_W+1)'(1);
      else if (!alloc_fire && update_valid)
        count_q <= count_q - (TAG_W+1)'(1);
    end
  end

endmodule

// File: tb/tb_branch_update_queue.sv
// Directed self-checking bench for branch_update_queue.
module tb_branch_update_queue;
  logic       clock = 1'b0;
  logic       reset;
  logic       alloc_valid;
  logic [4:0] alloc_pht_index;
  logic       alloc_prediction;
  logic       alloc_ready;
  logic [2:0] alloc_tag;
  logic       resolve_valid;
  logic [2:0] resolve_tag;
  logic       resolve_taken;
  logic       update_valid;
  logic [4:0] update_pht_index;
  logic       update_result;
  logic       mispredict;
  logic [3:0] count;

  int checks = 0;
  int errors = 0;

  branch_update_queue #(.DEPTH(8), .TAG_W(3), .IDX_W(5)) dut (
    .clock(clock), .reset(reset),
    .alloc_valid(alloc_valid), .alloc_pht_index(alloc_pht_index),
    .alloc_prediction(alloc_prediction), .alloc_ready(alloc_ready), .alloc_tag(alloc_tag),
    .resolve_valid(resolve_valid), .resolve_tag(resolve_tag), .resolve_taken(resolve_taken),
    .update_valid(update_valid), .update_pht_index(update_pht_index),
    .update_result(update_result), .mispredict(mispredict), .count(count)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_upd(input string tag, input logic v, input logic [4:0] idx,
                           input logic res, input logic mis);
    check({tag, ".update_valid"}, 32'(update_valid), 32'(v));
    check({tag, ".update_pht_index"}, 32'(update_pht_index), 32'(idx));
    check({tag, ".update_result"}, 32'(update_result), 32'(res));
    check({tag, ".mispredict"}, 32'(mispredict), 32'(mis));
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    alloc_valid = 1'b0; alloc_pht_index = '0; alloc_prediction = 1'b0;
    resolve_valid = 1'b0; resolve_tag = '0; resolve_taken = 1'b0;

    // 1: reset
    tick(); tick();
    reset = 1'b0;
    check("rst.alloc_ready", 32'(alloc_ready), 32'd1);
    check("rst.alloc_tag", 32'(alloc_tag), 32'd0);
    check("rst.count", 32'(count), 32'd0);
    check_upd("rst", 1'b0, 5'd0, 1'b0, 1'b0);

    // 2: fill, then a dropped ninth allocation
    for (int i = 0; i < 8; i++) begin
      alloc_valid = 1'b1; alloc_pht_index = 5'(i); alloc_prediction = 1'b0;
      check($sformatf("fill.tag%0d", i), 32'(alloc_tag), 32'(i));
      tick();
    end
    alloc_valid = 1'b0;
    check("full.count", 32'(count), 32'd8);
    check("full.alloc_ready", 32'(alloc_ready), 32'd0);
    alloc_valid = 1'b1; alloc_pht_index = 5'd9;
    tick();
    alloc_valid = 1'b0;
    check("drop.count", 32'(count), 32'd8);
    check("drop.alloc_tag", 32'(alloc_tag), 32'd0);
    check_upd("full", 1'b0, 5'd0, 1'b0, 1'b0);
    do_reset();
    check("rst2.count", 32'(count), 32'd0);

    // 3: out-of-order resolution, in-order retirement
    alloc_valid = 1'b1;
    alloc_pht_index = 5'd0; alloc_prediction = 1'b1; tick();
    alloc_pht_index = 5'd1; alloc_prediction = 1'b0; tick();
    alloc_pht_index = 5'd2; alloc_prediction = 1'b1; tick();
    alloc_valid = 1'b0;
    check("ooo.count3", 32'(count), 32'd3);
    resolve_valid = 1'b1; resolve_tag = 3'd2; resolve_taken = 1'b1; tick();
    check_upd("ooo.tag2only", 1'b0, 5'd0, 1'b0, 1'b0);
    resolve_tag = 3'd0; resolve_taken = 1'b1; tick();
    resolve_valid = 1'b0;
    check_upd("ooo.ret0", 1'b1, 5'd0, 1'b1, 1'b0);
    resolve_valid = 1'b1; resolve_tag = 3'd1; resolve_taken = 1'b0; tick();
    resolve_valid = 1'b0;
    check_upd("ooo.ret1", 1'b1, 5'd1, 1'b0, 1'b0);
    check("ooo.count2", 32'(count), 32'd2);
    tick();
    check_upd("ooo.ret2", 1'b1, 5'd2, 1'b1, 1'b0);
    check("ooo.count1", 32'(count), 32'd1);
    tick();
    check_upd("ooo.empty", 1'b0, 5'd0, 1'b0, 1'b0);
    check("ooo.count0", 32'(count), 32'd0);

    // 4: misprediction flush
    do_reset();
    alloc_valid = 1'b1;
    alloc_pht_index = 5'h0A; alloc_prediction = 1'b0; tick();
    alloc_pht_index = 5'h0B; alloc_prediction = 1'b1; tick();
    alloc_pht_index = 5'h0C; alloc_prediction = 1'b1; tick();
    alloc_valid = 1'b0;
    resolve_valid = 1'b1; resolve_tag = 3'd0; resolve_taken = 1'b1; tick();
    resolve_valid = 1'b0;
    check_upd("mis", 1'b1, 5'h0A, 1'b1, 1'b1);
    check("mis.alloc_ready", 32'(alloc_ready), 32'd0);
    alloc_valid = 1'b1; alloc_pht_index = 5'h1F; alloc_prediction = 1'b1;
    tick();
    alloc_valid = 1'b0;
    check("flush.count", 32'(count), 32'd0);
    check("flush.alloc_tag", 32'(alloc_tag), 32'd0);
    check("flush.alloc_ready", 32'(alloc_ready), 32'd1);
    resolve_valid = 1'b1; resolve_tag = 3'd1; resolve_taken = 1'b1; tick();
    resolve_valid = 1'b0;
    check_upd("flush.stale", 1'b0, 5'd0, 1'b0, 1'b0);
    tick();
    check_upd("flush.stale2", 1'b0, 5'd0, 1'b0, 1'b0);
    check("flush.count2", 32'(count), 32'd0);

    // 5: streaming with wrap-around; alloc and retire overlap from step 2 on
    for (int i = 0; i < 12; i++) begin
      alloc_valid = 1'b1; alloc_pht_index = 5'(16 + i); alloc_prediction = 1'(i & 1);
      check($sformatf("strm.tag%0d", i), 32'(alloc_tag), 32'(i % 8));
      check($sformatf("strm.count%0d", i), 32'(count), 32'(i < 2 ? i : 2));
      if (i >= 1) begin
        resolve_valid = 1'b1; resolve_tag = 3'((i - 1) % 8); resolve_taken = 1'((i - 1) & 1);
      end
      if (i >= 2)
        check_upd($sformatf("strm.upd%0d", i - 2), 1'b1, 5'(16 + i - 2), 1'((i - 2) & 1), 1'b0);
      tick();
    end
    alloc_valid = 1'b0;
    resolve_valid = 1'b1; resolve_tag = 3'd3; resolve_taken = 1'b1;
    check_upd("strm.upd10", 1'b1, 5'd26, 1'b0, 1'b0);
    tick();
    resolve_valid = 1'b0;
    check_upd("strm.upd11", 1'b1, 5'd27, 1'b1, 1'b0);
    tick();
    check("strm.drain", 32'(count), 32'd0);
    check("strm.tail", 32'(alloc_tag), 32'd4);

    // 6: reset in mid-operation
    do_reset();
    for (int i = 0; i < 5; i++) begin
      alloc_valid = 1'b1; alloc_pht_index = 5'(i + 3); alloc_prediction = 1'b0;
      tick();
    end
    alloc_valid = 1'b0;
    resolve_valid = 1'b1; resolve_tag = 3'd1; resolve_taken = 1'b0; tick();
    resolve_tag = 3'd0; tick();
    resolve_valid = 1'b0;
    check_upd("mid.pre", 1'b1, 5'd3, 1'b0, 1'b0);
    reset = 1'b1; alloc_valid = 1'b1;
    resolve_valid = 1'b1; resolve_tag = 3'd2; resolve_taken = 1'b1;
    tick();
    reset = 1'b0; alloc_valid = 1'b0; resolve_valid = 1'b0;
    check("mid.count", 32'(count), 32'd0);
    check_upd("mid.post", 1'b0, 5'd0, 1'b0, 1'b0);
    resolve_valid = 1'b1; resolve_tag = 3'd1; resolve_taken = 1'b1; tick();
    resolve_valid = 1'b0;
    check_upd("mid.stale", 1'b0, 5'd0, 1'b0, 1'b0);
    check("mid.count2", 32'(count), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
